// File: rtl/aes_decrypt_sequencer.sv
// aes_decrypt_sequencer: control FSM stepping an iterative AES-128 inverse-cipher datapath
module aes_decrypt_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int KS_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       ks_done,
  output logic       ks_start,
  output logic       state_load,
  output logic       state_we,
  output logic [2:0] op_sel,
  output logic [3:0] round_idx,
  output logic [1:0] col_sel,
  output logic       aes_ready,
  output logic       busy,
  output logic       ks_err
);
  localparam int CW = $clog2(KS_TIMEOUT + 1);
  typedef enum logic [3:0] {IDLE, KEY_EXP, LOAD, ADD_INIT, SHIFT, SUB, ADD, MIX, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [3:0] r_round;
  logic [1:0] r_col;
  logic r_ks_err;
  logic w_timeout;
  // ks_done arriving on the final allowed cycle wins over the timeout
  assign w_timeout = (r_state == KEY_EXP) && !ks_done && (r_cnt == CW'(KS_TIMEOUT - 1));
  assign ks_err = r_ks_err;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_round  <= '0;
      r_col    <= '0;
      r_ks_err <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= (r_state == KEY_EXP) ? r_cnt + 1'b1 : '0;
      r_col    <= (r_state == MIX) ? r_col + 1'b1 : 2'd0;
      r_round  <= (r_state == LOAD) ? 4'(NUM_ROUNDS) :
                  ((r_state == ADD_INIT) || (r_state == MIX && r_col == 2'd3)) ? r_round - 1'b1 : r_round;
      r_ks_err <= (r_state == IDLE && start) ? 1'b0 : (w_timeout ? 1'b1 : r_ks_err);
    end
  end
  always_comb begin
    w_next     = r_state;
    ks_start   = 1'b0;
    state_load = 1'b0;
    state_we   = 1'b0;
    op_sel     = 3'd0;
    round_idx  = 4'd0;
    col_sel    = 2'd0;
    aes_ready  = 1'b0;
    case (r_state)
      IDLE:     w_next = start ? KEY_EXP : IDLE;
      KEY_EXP: begin
        ks_start = (r_cnt == '0);
        w_next   = ks_done ? LOAD : (w_timeout ? IDLE : KEY_EXP);
      end
      LOAD: begin
        state_load = 1'b1;
        w_next     = ADD_INIT;
      end
      ADD_INIT: begin
        op_sel    = 3'd1;
        round_idx = r_round;
        state_we  = 1'b1;
        w_next    = SHIFT;
      end
      SHIFT: begin
        op_sel   = 3'd2;
        state_we = 1'b1;
        w_next   = SUB;
      end
      SUB: begin
        op_sel   = 3'd3;
        state_we = 1'b1;
        w_next   = ADD;
      end
      ADD: begin
        op_sel    = 3'd1;
        round_idx = r_round;
        state_we  = 1'b1;
        w_next    = (r_round == 4'd0) ? DONE : MIX;
      end
      MIX: begin
        op_sel   = 3'd4;
        col_sel  = r_col;
        state_we = 1'b1;
        w_next   = (r_col == 2'd3) ? SHIFT : MIX;
      end
      DONE: begin
        aes_ready = 1'b1;
        w_next    = start ? DONE : IDLE;
      end
      default:  w_next = IDLE;
    endcase
    busy = (r_state != IDLE) && (r_state != DONE);
  end
endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// tb_aes_decrypt_sequencer: randomized scenario bench against a trace-level reference of the decrypt schedule
module tb_aes_decrypt_sequencer;
  logic clk, reset_n, start, ks_done;
  logic ks_start, state_load, state_we, aes_ready, busy, ks_err;
  logic [2:0] op_sel;
  logic [3:0] round_idx;
  logic [1:0] col_sel;
  int n_checks = 0;
  int n_fail = 0;

  aes_decrypt_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ks_done(ks_done),
    .ks_start(ks_start), .state_load(state_load), .state_we(state_we),
    .op_sel(op_sel), .round_idx(round_idx), .col_sel(col_sel),
    .aes_ready(aes_ready), .busy(busy), .ks_err(ks_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // invariants sampled mid-cycle on every cycle out of reset
  always @(negedge clk) begin
    if (reset_n) begin
      n_checks++;
      if (round_idx > 4'd10 || (col_sel != 2'd0 && op_sel != 3'd4) || state_we !== (op_sel != 3'd0)) begin
        n_fail++;
        $display("FAIL bounds: round_idx=%0d col_sel=%0d op_sel=%0d state_we=%b", round_idx, col_sel, op_sel, state_we);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one full decrypt: dly KEY_EXP cycles before ks_done, optional start drop at trace index,
  // DONE hold cycles, and spurious ks_done pulses on every SUB cycle
  task automatic do_run(input int dly, input int drop_at, input int hold, input bit spur);
    logic [8:0] exp_q[$];
    logic [8:0] got;
    int n, errs, first, ksp, herr;
    exp_q = {};
    exp_q.push_back(9'd0);
    exp_q.push_back({3'd1, 4'd10, 2'd0});
    for (int rd = 9; rd >= 0; rd--) begin
      exp_q.push_back({3'd2, 4'd0, 2'd0});
      exp_q.push_back({3'd3, 4'd0, 2'd0});
      exp_q.push_back({3'd1, 4'(rd), 2'd0});
      if (rd > 0) for (int c = 0; c < 4; c++) exp_q.push_back({3'd4, 4'd0, 2'(c)});
    end
    start = 1;
    step();
    n_checks++;
    if ({ks_start, busy, ks_err, state_we} !== 4'b1100) begin
      n_fail++;
      $display("FAIL kexp_entry: {ks_start,busy,ks_err,we}=%b expected 1100", {ks_start, busy, ks_err, state_we});
    end
    ksp = 0;
    repeat (dly) begin
      step();
      if (ks_start) ksp++;
    end
    n_checks++;
    if (ksp !== 0) begin
      n_fail++;
      $display("FAIL ks_start_pulse: extra pulses=%0d expected 0", ksp);
    end
    ks_done = 1;
    step();
    ks_done = 0;
    n = 0; errs = 0; first = -1;
    while (!aes_ready && n < 200) begin
      got = {op_sel, round_idx, col_sel};
      if (n >= exp_q.size() || got !== exp_q[n] || state_load !== (n == 0) || busy !== 1'b1) begin
        errs++;
        if (first < 0) first = n;
      end
      if (n == drop_at) start = 0;
      ks_done = spur && (op_sel == 3'd3);
      step();
      n++;
    end
    ks_done = 0;
    n_checks++;
    if (n !== 68) begin
      n_fail++;
      $display("FAIL latency: cycles=%0d expected 68", n);
    end
    n_checks++;
    if (errs !== 0) begin
      n_fail++;
      $display("FAIL op_trace: %0d bad cycles, first at %0d, expected 0", errs, first);
    end
    n_checks++;
    if ({aes_ready, busy, state_we, op_sel, ks_err} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL done_outputs: got %b expected 1000000", {aes_ready, busy, state_we, op_sel, ks_err});
    end
    if (start) begin
      herr = 0;
      repeat (hold) begin
        step();
        if (!aes_ready || busy) herr++;
      end
      n_checks++;
      if (herr !== 0) begin
        n_fail++;
        $display("FAIL done_hold: bad cycles=%0d expected 0", herr);
      end
      start = 0;
    end
    step();
    n_checks++;
    if ({aes_ready, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL to_idle: {aes_ready,busy}=%b expected 00", {aes_ready, busy});
    end
  endtask

  task automatic test_reset();
    reset_n = 0; start = 0; ks_done = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ks_start, state_load, state_we, op_sel, round_idx, col_sel, aes_ready, busy, ks_err} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0000",
               {ks_start, state_load, state_we, op_sel, round_idx, col_sel, aes_ready, busy, ks_err});
    end
    reset_n = 1;
    step();
  endtask

  task automatic test_nominal();
    do_run(5, -1, 0, 1'b0);
  endtask

  task automatic test_handshake();
    do_run($urandom_range(1, 30), -1, 10, 1'b0);
  endtask

  task automatic test_timeout();
    int n, ksp;
    start = 1;
    step();
    start = 0;
    n_checks++;
    if (ks_start !== 1'b1) begin
      n_fail++;
      $display("FAIL to_kstart: ks_start=%b expected 1", ks_start);
    end
    n = 0; ksp = 0;
    while (busy && n < 400) begin
      step();
      n++;
      if (ks_start) ksp++;
    end
    n_checks++;
    if (n !== 255 || ksp !== 0) begin
      n_fail++;
      $display("FAIL timeout_len: cycles=%0d pulses=%0d expected 255 and 0", n, ksp);
    end
    repeat (3) step();
    n_checks++;
    if ({ks_err, busy, aes_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL err_sticky: {ks_err,busy,aes_ready}=%b expected 100", {ks_err, busy, aes_ready});
    end
    // ks_done on the very last permitted cycle must still be accepted
    do_run(254, -1, 0, 1'b0);
  endtask

  task automatic test_mid_reset();
    int n, bad;
    start = 1;
    step();
    repeat (3) step();
    ks_done = 1;
    step();
    ks_done = 0;
    n = 0;
    while (!(op_sel == 3'd4 && col_sel == 2'd2) && n < 100) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL reach_mix: cycles=%0d expected <100", n);
    end
    #2 reset_n = 0;
    #1;
    n_checks++;
    if ({ks_start, state_load, state_we, op_sel, round_idx, col_sel, aes_ready, busy, ks_err} !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0000",
               {ks_start, state_load, state_we, op_sel, round_idx, col_sel, aes_ready, busy, ks_err});
    end
    start = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    bad = 0;
    repeat (80) begin
      step();
      if (aes_ready || busy) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL no_resume: active cycles=%0d expected 0", bad);
    end
    do_run($urandom_range(0, 20), -1, $urandom_range(0, 5), 1'b0);
  endtask

  task automatic test_spurious();
    ks_done = 1;
    step();
    ks_done = 0;
    n_checks++;
    if ({busy, ks_start, state_load} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_ks_done: {busy,ks_start,load}=%b expected 000", {busy, ks_start, state_load});
    end
    step();
    do_run($urandom_range(0, 20), 35, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      do_run($urandom_range(0, 60), ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 67)) : -1,
             $urandom_range(0, 8), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 4)) step();
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_handshake();
    test_timeout();
    test_mid_reset();
    test_spurious();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
